// File: rtl/rr_arb4_sel_pkg.sv
// rr_arb4_sel_pkg: shared state encoding and sizing for the round-robin arbiter
package rr_arb4_sel_pkg;
  localparam int N_REQ = 4;
  localparam int IDX_W = 2;
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;
endpackage

// File: rtl/rr_arb4_sel_if.sv
// rr_arb4_sel_if: request/release handshake and encoded-select outputs of the arbiter
interface rr_arb4_sel_if;
  import rr_arb4_sel_pkg::*;
  logic [N_REQ-1:0] req;
  logic done;
  logic gnt_valid;
  logic y0;
  logic y1;
  logic busy;
  logic timeout;
  modport master (output req, done, input gnt_valid, y0, y1, busy, timeout);
  modport slave (input req, done, output gnt_valid, y0, y1, busy, timeout);
endinterface

// File: rtl/rr_arb4_sel_pick4.sv
// rr_pick4: first asserted request scanning upward from ptr with wrap
module rr_pick4
  import rr_arb4_sel_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             any,
  output logic [IDX_W-1:0] idx
);
  assign any = |req;
  // scan from the farthest offset down so the nearest request overwrites last
  always_comb begin
    idx = ptr;
    for (int i = N_REQ - 1; i >= 0; i--)
      idx = req[ptr + IDX_W'(i)] ? ptr + IDX_W'(i) : idx;
  end
endmodule

// File: rtl/rr_arb4_sel.sv
// rr_arb4_sel: 4-way round-robin arbiter with hold timer and one-cycle gap between owners
module rr_arb4_sel
  import rr_arb4_sel_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input logic         clk,
  input logic         rst_n,
  rr_arb4_sel_if.slave bus
);
  localparam int CNT_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);
  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] owner;
  logic [CNT_W-1:0] hold_cnt;
  logic             gnt_valid;
  logic             busy;
  logic             timeout;
  logic             any;
  logic [IDX_W-1:0] idx;
  logic             own_req;
  logic             expired;
  logic             rel;
  rr_pick4 u_pick (
    .req (bus.req),
    .ptr (ptr),
    .any (any),
    .idx (idx)
  );
  assign own_req = bus.req[owner];
  assign expired = (MAX_HOLD != 0) && (hold_cnt == HOLD_LIM);
  assign rel     = bus.done | ~own_req | expired;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      owner     <= '0;
      hold_cnt  <= '0;
      gnt_valid <= 1'b0;
      busy      <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_RELEASE: begin
          timeout   <= 1'b0;
          state     <= any ? ST_GRANT : ST_IDLE;
          busy      <= any;
          gnt_valid <= any;
          owner     <= any ? idx : owner;
          hold_cnt  <= any ? CNT_W'(1) : '0;
        end
        ST_GRANT: begin
          // timeout flags only a release that nothing but the timer caused
          if (rel) begin
            state     <= ST_RELEASE;
            gnt_valid <= 1'b0;
            ptr       <= owner + 1'b1;
            hold_cnt  <= '0;
            timeout   <= expired & ~bus.done & own_req;
          end else begin
            hold_cnt  <= hold_cnt + CNT_W'(hold_cnt != '1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
  assign bus.gnt_valid = gnt_valid;
  assign bus.y0        = owner[1];
  assign bus.y1        = owner[0];
  assign bus.busy      = busy;
  assign bus.timeout   = timeout;
endmodule
